ts_pack_arbiter: RTL

Sequencer and arbiter for the shared single-port 32-bit sample RAM in the TS recorder path. It packs 10-bit capture samples three per 32-bit word and commits each full word to RAM. It fetches and unpacks words for the readout side. Write commits and read fetches are arbitrated round-robin onto one RAM port per cycle, and the block maintains word-level full/empty status.

---
 rtl/ts_pkg.sv | 29 ++
 rtl/ts_pack_arbiter_if.sv | 37 +++
 rtl/ts_slot_packer.sv | 50 +++++
 rtl/ts_pack_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and constants for the TS recorder sample-RAM sequencer:
// FSM encoding, sample/word geometry, grant identifiers and a slot extractor.
package ts_pkg;

  localparam int SAMPLE_W = 10;
  localparam int WORD_W   = 32;
  localparam int SLOTS    = 3;

  localparam logic GRANT_ID_READ  = 1'b0;
  localparam logic GRANT_ID_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_W = 2'd1,
    ST_GRANT_R = 2'd2,
    ST_RD_CAP  = 2'd3
  } ts_state_e;

  // Sample k of a packed word lives at bits [10k+9:10k]; bits [31:30] carry nothing.
  function automatic logic [SAMPLE_W-1:0] slot_sample(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        idx);
    case (idx)
      2'd0:    slot_sample = word[9:0];
      2'd1:    slot_sample = word[19:10];
      default: slot_sample = word[29:20];
    endcase
  endfunction

endpackage

// File: rtl/ts_pack_arbiter_if.sv
// Capture, readout, RAM-port and status signals of the sample-RAM sequencer.
interface ts_pack_arbiter_if #(
  parameter int ADDR_W = 5
);
  // Write side: a sample transfers on a cycle where WR_VALID && WR_READY are both high.
  // Read side: RD_REQ is a one-cycle request, ignored while RD_BUSY=1; each accepted
  // request ends in exactly one RD_VALID pulse or one UNDERRUN pulse.
  logic              WR_VALID;
  logic [9:0]        WR_DATA;
  logic              WR_READY;
  logic              RD_REQ;
  logic              RD_BUSY;
  logic              RD_VALID;
  logic [9:0]        RD_DATA;
  logic              UNDERRUN;
  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic [31:0]       MEM_RDATA;
  logic [ADDR_W:0]   WORD_COUNT;
  logic              FULL;
  logic              EMPTY;

  modport master (
    output WR_VALID, WR_DATA, RD_REQ, MEM_RDATA,
    input  WR_READY, RD_BUSY, RD_VALID, RD_DATA, UNDERRUN,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, WORD_COUNT, FULL, EMPTY
  );

  modport slave (
    input  WR_VALID, WR_DATA, RD_REQ, MEM_RDATA,
    output WR_READY, RD_BUSY, RD_VALID, RD_DATA, UNDERRUN,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, WORD_COUNT, FULL, EMPTY
  );

endinterface

// File: rtl/ts_slot_packer.sv
// Packs three 10-bit samples into one word and holds it as a pending commit
// until the arbiter has written it to RAM.
module ts_slot_packer
  import ts_pkg::*;
(
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                wr_valid,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                commit_done,
  output logic                wr_ready,
  output logic                commit_pend,
  output logic                commit_soon,
  output logic [WORD_W-1:0]   pack_word
);

  logic [3*SAMPLE_W-1:0] pack_q;
  logic [1:0]            slot_q;
  logic                  accept;

  assign wr_ready  = !commit_pend;
  assign accept    = wr_valid && wr_ready;
  // Lets the arbiter grant the commit in the cycle right after the third sample.
  assign commit_soon = commit_pend || (accept && slot_q == 2'd2);
  assign pack_word = {2'b00, pack_q};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pack_q      <= '0;
      slot_q      <= 2'd0;
      commit_pend <= 1'b0;
    end else begin
      if (commit_done) commit_pend <= 1'b0;
      if (accept) begin
        case (slot_q)
          2'd0:    pack_q[9:0]   <= wr_data;
          2'd1:    pack_q[19:10] <= wr_data;
          default: pack_q[29:20] <= wr_data;
        endcase
        if (slot_q == 2'd2) begin
          slot_q      <= 2'd0;
          commit_pend <= 1'b1;
        end else begin
          slot_q <= slot_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ts_pack_arbiter.sv
// Round-robin sequencer for the shared sample RAM: commits packed words,
// fetches words for readout, unpacks them and tracks word-level fill status.
module ts_pack_arbiter
  import ts_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic               CLOCK,
  input  logic               RESET,
  ts_pack_arbiter_if.slave   bus,
  output ts_state_e          dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  ts_state_e           state;
  logic                last_grant;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     word_count;
  logic [WORD_W-1:0]   unpack_word;
  logic [1:0]          unpack_slots;
  logic                rd_pend, rd_busy, rd_valid, underrun;
  logic [SAMPLE_W-1:0] rd_data;

  logic                commit_pend, commit_soon, wr_ready;
  logic [WORD_W-1:0]   pack_word;
  logic                full, req_ok, hit, need_fetch, no_data, cand_w, cand_r;

  ts_slot_packer u_packer (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .wr_valid    (bus.WR_VALID),
    .wr_data     (bus.WR_DATA),
    .commit_done (state == ST_GRANT_W),
    .wr_ready    (wr_ready),
    .commit_pend (commit_pend),
    .commit_soon (commit_soon),
    .pack_word   (pack_word)
  );

  assign full       = (word_count == DEPTH_CNT);
  assign req_ok     = bus.RD_REQ && !rd_busy;
  assign hit        = req_ok && (unpack_slots != 2'd0);
  assign need_fetch = req_ok && (unpack_slots == 2'd0) && (word_count != '0);
  assign no_data    = req_ok && (unpack_slots == 2'd0) && (word_count == '0);
  assign cand_w     = commit_soon && !full;
  assign cand_r     = rd_pend || need_fetch;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      last_grant   <= GRANT_ID_READ;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      word_count   <= '0;
      unpack_word  <= '0;
      unpack_slots <= 2'd0;
      rd_pend      <= 1'b0;
      rd_busy      <= 1'b0;
      rd_valid     <= 1'b0;
      underrun     <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_valid <= 1'b0;
      underrun <= 1'b0;
      // Busy spans the request up to and including the RD_VALID cycle.
      if (hit || need_fetch) rd_busy <= 1'b1;
      else if (rd_valid)     rd_busy <= 1'b0;
      if (hit) begin
        rd_data      <= slot_sample(unpack_word, 2'(SLOTS) - unpack_slots);
        rd_valid     <= 1'b1;
        unpack_slots <= unpack_slots - 2'd1;
      end
      if (no_data)    underrun <= 1'b1;
      if (need_fetch) rd_pend  <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cand_w && (!cand_r || last_grant == GRANT_ID_READ)) begin
            state <= ST_GRANT_W;
          end else if (cand_r) begin
            state   <= ST_GRANT_R;
            rd_pend <= 1'b0;
          end
        end
        ST_GRANT_W: begin
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          word_count <= word_count + (ADDR_W+1)'(1);
          last_grant <= GRANT_ID_WRITE;
          state      <= ST_IDLE;
        end
        ST_GRANT_R: begin
          rd_ptr     <= rd_ptr + ADDR_W'(1);
          word_count <= word_count - (ADDR_W+1)'(1);
          last_grant <= GRANT_ID_READ;
          state      <= ST_RD_CAP;
        end
        default: begin
          unpack_word  <= bus.MEM_RDATA;
          unpack_slots <= 2'(SLOTS - 1);
          rd_data      <= slot_sample(bus.MEM_RDATA, 2'd0);
          rd_valid     <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.MEM_EN    = 1'b0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_ADDR  = '0;
    bus.MEM_WDATA = '0;
    case (state)
      ST_GRANT_W: begin
        bus.MEM_EN    = 1'b1;
        bus.MEM_WE    = 1'b1;
        bus.MEM_ADDR  = wr_ptr;
        bus.MEM_WDATA = pack_word;
      end
      ST_GRANT_R: begin
        bus.MEM_EN   = 1'b1;
        bus.MEM_ADDR = rd_ptr;
      end
      default: ;
    endcase
  end

  assign bus.WR_READY   = wr_ready;
  assign bus.RD_BUSY    = rd_busy;
  assign bus.RD_VALID   = rd_valid;
  assign bus.RD_DATA    = rd_data;
  assign bus.UNDERRUN   = underrun;
  assign bus.WORD_COUNT = word_count;
  assign bus.FULL       = full;
  assign bus.EMPTY      = (word_count == '0) && (unpack_slots == 2'd0);
  assign dbg_state      = state;

endmodule
